// File: rtl/game_control.sv
// Control FSM for the auto-pets game. Sequences idle, team select, shop,
// battle, result and game over, driving datapath commands from its status
// strobes. Adds a battle timeout (forced loss) and a timed result-display hold.
module game_control #(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned HOLD_CYC    = 50,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       chosenDelay2,
    input  logic       actionFight,
    input  logic       battleDone,
    input  logic       battleWin,
    input  logic       alive,
    output logic [2:0] ns,
    output logic [2:0] ps,
    output logic       load_regs,
    output logic       decr_lives,
    output logic       rewards,
    output logic       result_win,
    output logic       timed_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SHOP   = 3'd2,
        BATTLE = 3'd3,
        RESULT = 3'd4,
        OVER   = 3'd5
    } state_t;

    // Last count value of each timed phase; TO_LAST is unused when the timeout is disabled.
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           ps_reg;
    state_t           ns_next;
    logic [CNT_W-1:0] count_reg;
    logic             start_q_reg;
    logic             lost_reg;
    logic             dead_reg;
    logic             result_win_reg;
    logic             timed_out_reg;

    logic             start_rise;
    logic             timeout_hit;
    logic             rewards_next;
    logic             decr_next;

    // A held start key yields a single rising edge, so it advances one state only.
    assign start_rise  = start & ~start_q_reg;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (count_reg == TO_LAST);

    // Next-state decode plus Mealy outcome pulses in the final BATTLE cycle.
    always_comb begin
        ns_next      = ps_reg;
        rewards_next = 1'b0;
        decr_next    = 1'b0;
        case (ps_reg)
            IDLE:   if (start_rise)   ns_next = SELECT;
            SELECT: if (chosenDelay2) ns_next = SHOP;
            SHOP:   if (actionFight)  ns_next = BATTLE;
            BATTLE: begin
                // A real battle end beats a simultaneous timeout.
                if (battleDone) begin
                    ns_next = RESULT;
                    if (battleWin) rewards_next = 1'b1;
                    else           decr_next    = 1'b1;
                end else if (timeout_hit) begin
                    ns_next   = RESULT;
                    decr_next = 1'b1;
                end
            end
            RESULT: begin
                if (count_reg == HOLD_LAST)
                    ns_next = (lost_reg && dead_reg) ? OVER : SELECT;
            end
            OVER:   if (start_rise)   ns_next = IDLE;
            default: ns_next = IDLE;
        endcase
    end

    assign ns         = ns_next;
    assign ps         = ps_reg;
    assign load_regs  = (ps_reg == IDLE);
    assign rewards    = rewards_next;
    assign decr_lives = decr_next;
    assign result_win = result_win_reg;
    assign timed_out  = timed_out_reg;

    // State, edge detector, phase counter and latched battle outcome.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_reg         <= IDLE;
            count_reg      <= '0;
            start_q_reg    <= 1'b0;
            lost_reg       <= 1'b0;
            dead_reg       <= 1'b0;
            result_win_reg <= 1'b0;
            timed_out_reg  <= 1'b0;
        end else begin
            start_q_reg <= start;
            ps_reg      <= ns_next;

            // Counter restarts on entry to a timed phase and saturates instead of wrapping.
            if ((ps_reg != ns_next) && (ns_next == BATTLE || ns_next == RESULT))
                count_reg <= '0;
            else if (count_reg != CNT_MAX)
                count_reg <= count_reg + CNT_W'(1);

            if (ps_reg == BATTLE) begin
                if (battleDone) begin
                    result_win_reg <= battleWin;
                    timed_out_reg  <= 1'b0;
                    lost_reg       <= ~battleWin;
                    if (!battleWin) dead_reg <= ~alive;
                end else if (timeout_hit) begin
                    result_win_reg <= 1'b0;
                    timed_out_reg  <= 1'b1;
                    lost_reg       <= 1'b1;
                    dead_reg       <= ~alive;
                end
            end
        end
    end

endmodule
